// File: rtl/poly_eval.sv
// Horner-rule fixed-point polynomial evaluator, one multiply-add per clock.
// Optional macro POLY_EVAL_SATURATE_EN: saturate instead of wrap on overflow.
module poly_eval #(
  parameter int DEGREE = 2,
  parameter int XW     = 32,
  parameter int YW     = 64,
  parameter int FRAC   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [XW-1:0]            x_in,
  input  logic [(DEGREE+1)*YW-1:0] coef_in,
  output logic [YW-1:0]            y_out,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int PW = XW + YW;
  localparam int CW = $clog2(DEGREE + 1);

`ifdef POLY_EVAL_SATURATE_EN
  localparam logic [YW-1:0] Y_MAX = {1'b0, {(YW-1){1'b1}}};
  localparam logic [YW-1:0] Y_MIN = {1'b1, {(YW-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [YW-1:0]        coef_unpacked [0:DEGREE];
  logic [YW-1:0]        coef_reg      [0:DEGREE];
  logic signed [XW-1:0] x_reg;
  logic signed [YW-1:0] acc_reg;
  logic [CW-1:0]        cnt_reg;
  logic [YW-1:0]        y_out_reg;
  logic                 overflow_reg;

  logic                 load;
  logic                 step;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic                 q_ovf;
  logic [YW-1:0]        q_fit;
  logic [YW-1:0]        c_sel;
  logic [YW:0]          sum;
  logic                 s_ovf;
  logic [YW-1:0]        acc_next;

  assign load = (state_reg == S_IDLE) && start;
  assign step = (state_reg == S_STEP);

  // Coefficients are captured once, on the edge that leaves IDLE.
  genvar gi;
  generate
    for (gi = 0; gi <= DEGREE; gi++) begin : g_coef
      assign coef_unpacked[gi] = coef_in[gi*YW +: YW];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          coef_reg[gi] <= '0;
        end else if (load) begin
          coef_reg[gi] <= coef_unpacked[gi];
        end
      end
    end
  endgenerate

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = S_IDLE;
    case (state_reg)
      S_IDLE:  state_next = start ? S_STEP : S_IDLE;
      S_STEP:  state_next = (cnt_reg == '0) ? S_DONE : S_STEP;
      S_DONE:  state_next = start ? S_DONE : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      S_STEP:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Multiply-add: both the rescaled product and the sum are range-checked.
  always_comb begin
    prod    = PW'(acc_reg) * PW'(x_reg);
    shifted = prod >>> FRAC;
    q_ovf   = (shifted[PW-1:YW-1] != {(XW+1){shifted[YW-1]}});
`ifdef POLY_EVAL_SATURATE_EN
    q_fit   = q_ovf ? (shifted[PW-1] ? Y_MIN : Y_MAX) : shifted[YW-1:0];
`else
    q_fit   = shifted[YW-1:0];
`endif
    c_sel   = coef_reg[cnt_reg];
    sum     = {q_fit[YW-1], q_fit} + {c_sel[YW-1], c_sel};
    s_ovf   = sum[YW] ^ sum[YW-1];
`ifdef POLY_EVAL_SATURATE_EN
    acc_next = s_ovf ? (sum[YW] ? Y_MIN : Y_MAX) : sum[YW-1:0];
`else
    acc_next = sum[YW-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg        <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      y_out_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (load) begin
      x_reg        <= x_in;
      acc_reg      <= coef_unpacked[DEGREE];
      cnt_reg      <= CW'(DEGREE - 1);
      overflow_reg <= 1'b0;
    end else if (step) begin
      acc_reg      <= acc_next;
      overflow_reg <= overflow_reg | q_ovf | s_ovf;
      // y_out only ever sees the final accumulation.
      if (cnt_reg == '0) begin
        y_out_reg <= acc_next;
      end else begin
        cnt_reg <= cnt_reg - CW'(1);
      end
    end
  end

  assign y_out    = y_out_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_poly_eval.sv
// Directed bench for poly_eval (defaults DEGREE=2, XW=32, YW=64, FRAC=8)
// with a scoreboard queue of expected results.
module tb_poly_eval;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [31:0]  x_in;
  logic [191:0] coef_in;
  logic [63:0]  y_out;
  logic         busy;
  logic         done;
  logic         overflow;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] y;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  poly_eval dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .x_in     (x_in),
    .coef_in  (coef_in),
    .y_out    (y_out),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model on 128-bit integers with explicit range bounds.
  localparam logic signed [127:0] M_MAX = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] M_MIN = -M_MAX - 128'sd1;

  function automatic logic signed [127:0] fit_val(input logic signed [127:0] v);
`ifdef POLY_EVAL_SATURATE_EN
    if (v > M_MAX) return M_MAX;
    if (v < M_MIN) return M_MIN;
    return v;
`else
    logic signed [63:0] lo;
    lo = v[63:0];
    return 128'(lo);
`endif
  endfunction

  function automatic exp_t model(input logic signed [31:0] x, input logic signed [63:0] c2,
                                 input logic signed [63:0] c1, input logic signed [63:0] c0);
    logic signed [127:0] acc, v;
    logic signed [63:0]  cs [2];
    exp_t r;
    cs[0] = c0;
    cs[1] = c1;
    acc = 128'(c2);
    r.ovf = 1'b0;
    for (int k = 1; k >= 0; k--) begin
      v = (acc * 128'(x)) >>> 8;
      if (v > M_MAX || v < M_MIN) r.ovf = 1'b1;
      v = fit_val(v) + 128'(cs[k]);
      if (v > M_MAX || v < M_MIN) r.ovf = 1'b1;
      acc = fit_val(v);
    end
    r.y = acc[63:0];
    return r;
  endfunction

  task automatic run_eval(input string tag, input logic [31:0] x, input logic [63:0] c2,
                          input logic [63:0] c1, input logic [63:0] c0,
                          input logic [63:0] y_exp, input logic ovf_exp,
                          input bit pulse, input bit perturb, input int hold);
    int   lat;
    int   busy_cnt;
    exp_t e;
    @(negedge clk);
    x_in    = x;
    coef_in = {c2, c1, c0};
    start   = 1'b1;
    sb.push_back('{y_exp, ovf_exp});
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (pulse) start = 1'b0;
      if (perturb) begin
        x_in    = $urandom;
        coef_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
    end
    check({tag, ":done"}, 64'(done), 64'd1);
    check({tag, ":latency"}, 64'(lat), 64'd3);
    check({tag, ":busy_cycles"}, 64'(busy_cnt), 64'd2);
    check({tag, ":busy_at_done"}, 64'(busy), 64'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ":y_out"}, y_out, e.y);
      check({tag, ":overflow"}, 64'(overflow), 64'(e.ovf));
    end
    $display("[TB] %s x=%0h y_out=%0h overflow=%0b latency=%0d", tag, x, y_out, overflow, lat);
    if (pulse) begin
      @(negedge clk);
      check({tag, ":done_one_cycle"}, 64'(done), 64'd0);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, ":hold_done"}, 64'(done), 64'd1);
        check({tag, ":hold_y"}, y_out, y_exp);
        check({tag, ":hold_no_restart"}, 64'(busy), 64'd0);
      end
      start = 1'b0;
      @(negedge clk);
      check({tag, ":done_drop"}, 64'(done), 64'd0);
      check({tag, ":y_keep"}, y_out, y_exp);
    end
  endtask

  localparam logic [63:0] C2 = 64'd256;
  localparam logic [63:0] C1 = 64'd1024;
  localparam logic [63:0] C0 = -64'sd256;

  initial begin
    logic [63:0] ovf_y;
    exp_t        m;
    int          xi, ci2, ci1, ci0;

    rst_n   = 1'b0;
    start   = 1'b0;
    x_in    = '0;
    coef_in = '0;
    repeat (2) @(negedge clk);
    check("reset:y_out", y_out, 64'd0);
    check("reset:done", 64'(done), 64'd0);
    check("reset:busy", 64'(busy), 64'd0);
    check("reset:overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;

    run_eval("x3_hold",   32'd768,  C2, C1, C0, 64'd5120,   1'b0, 1'b0, 1'b0, 5);
    run_eval("xm2",      -32'sd512, C2, C1, C0, -64'sd1280, 1'b0, 1'b0, 1'b0, 0);
    run_eval("x0p5",      32'd128,  C2, C1, C0, 64'd320,    1'b0, 1'b0, 1'b0, 0);
    run_eval("floor",     32'd1,    C2, C1, C0, -64'sd252,  1'b0, 1'b0, 1'b0, 0);

`ifdef POLY_EVAL_SATURATE_EN
    ovf_y = 64'h7FFF_FFFF_FFFF_FEFF;
`else
    ovf_y = 64'h0000_0000_FFFF_FF00;
`endif
    run_eval("overflow", 32'h4000_0000, 64'h4000_0000_0000_0000, C1, C0, ovf_y, 1'b1, 1'b0, 1'b0, 0);
    run_eval("clean_perturb", 32'd768, C2, C1, C0, 64'd5120, 1'b0, 1'b0, 1'b1, 0);
    run_eval("pulse", 32'd128, C2, C1, C0, 64'd320, 1'b0, 1'b1, 1'b0, 0);

    for (int i = 0; i < 4; i++) begin
      xi  = int'($urandom_range(8191)) - 4096;
      ci2 = int'($urandom_range(65535)) - 32768;
      ci1 = int'($urandom_range(65535)) - 32768;
      ci0 = int'($urandom_range(65535)) - 32768;
      m = model(32'(xi), 64'(ci2), 64'(ci1), 64'(ci0));
      run_eval("random", 32'(xi), 64'(ci2), 64'(ci1), 64'(ci0), m.y, m.ovf, 1'b0, 1'b0, 0);
    end

    // Abort between E1 and E2; no result may appear afterwards.
    @(negedge clk);
    x_in    = -32'sd512;
    coef_in = {C2, C1, C0};
    start   = 1'b1;
    sb.push_back('{-64'sd1280, 1'b0});
    repeat (2) @(negedge clk);
    check("abort:busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort:y_out", y_out, 64'd0);
    check("abort:done", 64'(done), 64'd0);
    check("abort:busy", 64'(busy), 64'd0);
    check("abort:overflow", 64'(overflow), 64'd0);
    start = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort:no_result", 64'(done), 64'd0);
    run_eval("after_reset", 32'd1, C2, C1, C0, -64'sd252, 1'b0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/poly_eval.md
# poly_eval

Parametrised fixed-point polynomial evaluator for the general linear regressor datapath. It computes y = c[DEGREE]·x^DEGREE + … + c[1]·x + c[0] by Horner's rule, one multiply-add per clock. Degree, operand widths and fraction bits are set at elaboration, and coefficients are runtime inputs. It replaces the fixed x²+4x−1 function unit and keeps the same level start/done handshake and the same overflow reporting.

## Interface
Parameters:
- DEGREE, 2: polynomial degree; legal range ≥ 1.
- XW, 32: width of x_in, signed.
- YW, 64: width of coefficients, accumulator and y_out, signed.
- FRAC, 8: fraction bits shared by x, coefficients and y; all values are Q(W−FRAC).FRAC.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- start  in  1  level request; sampled only in IDLE.
- x_in  in  XW  operand x, signed.
- coef_in  in  (DEGREE+1)·YW  packed coefficients; c[k] = coef_in[k·YW +: YW], signed.
- y_out  out  YW  result, signed, registered.
- busy  out  1  high while in LOAD-completed/STEP states.
- done  out  1  result valid; held until start drops.
- overflow  out  1  sticky overflow for the current evaluation.

## Operation
- States and transitions:
  - IDLE → STEP when start = 1.
  - STEP → STEP while step counter > 0.
  - STEP → DONE after the last step.
  - DONE → IDLE when start = 0.
  - Any illegal encoding → IDLE.
- Edge leaving IDLE (E0):
  - Latch x_in and all of coef_in.
  - Load acc = c[DEGREE] and cnt = DEGREE−1.
  - Clear overflow and done; set busy = 1.
- Each STEP edge:
  - k = cnt.
  - p = acc·x, full width XW+YW signed.
  - q = p >>> FRAC (arithmetic shift, floor rounding).
  - acc = fit(fit(q) + c[k]).
  - If cnt = 0: load y_out with the new acc, set done = 1 and busy = 0, go to DONE. Otherwise decrement cnt.
- fit(v): v outside the signed YW range sets overflow (sticky until the next E0). The stored value is as defined in Configuration.
- DONE:
  - done, y_out and overflow hold.
  - On the edge where start = 0 is seen: done = 0, go to IDLE; y_out and overflow keep their values.
- Inputs are ignored outside E0. Changing x_in or coef_in mid-evaluation has no effect.
- A start drop during STEP does not abort the evaluation. DONE is still entered, done is high for exactly one cycle, then the block returns to IDLE.
- Reset value of every output: y_out = 0, done = 0, busy = 0, overflow = 0, state = IDLE. Internal acc, cnt and latched operands are also 0.
- Reset mid-evaluation: immediate abort, all outputs at reset values. No result is produced.

## Timing
- Latency: done rises DEGREE cycles after E0, i.e. on edge E_DEGREE.
- Throughput: one evaluation per DEGREE+2 cycles minimum, because start must drop for one sampled edge.
- y_out changes only on edge E_DEGREE; it never shows partial accumulations.
- The multiplier is combinational within one cycle; the critical path is the XW×YW multiply plus the YW add.

## Configuration
- POLY_EVAL_SATURATE_EN defined: fit() clamps to 2^(YW−1)−1 or −2^(YW−1). Overflow is still flagged.
- POLY_EVAL_SATURATE_EN undefined: fit() keeps the low YW bits (two's-complement wrap). Overflow is flagged.

## Test plan
All scenarios use defaults (DEGREE = 2, XW = 32, YW = 64, FRAC = 8).
- c2 = 256, c1 = 1024, c0 = −256 (x²+4x−1), x_in = 768 (3.0), start held high → done = 1 at E2; y_out = 5120 (20.0); overflow = 0; busy high for 2 cycles.
- Same coefficients, x_in = −512 and x_in = 128, in separate runs with start dropped between them:
  - x_in = −512 → y_out = −1280 (−5.0).
  - x_in = 128 → y_out = 320 (1.25).
  - x_in = 1 → y_out = −252 (floor check).
- c2 = 2^62, c1 = 1024, c0 = −256, x_in = 2^30 → overflow = 1 at done.
  - With POLY_EVAL_SATURATE_EN: y_out = 64'h7FFF_FFFF_FFFF_FEFF.
  - Without it: y_out matches the wrapped reference model.
  - The next clean evaluation clears overflow to 0.
- Handshake: hold start high 5 cycles after done → done and y_out stable, no restart. Drop start → done = 0 after one edge, state IDLE. Change x_in during STEP → result unaffected.
- Start pulsed for 1 cycle → done high for exactly 1 cycle at E2, then IDLE.
- Assert rst_n = 0 between E1 and E2 → all outputs 0 immediately. After release, start → a correct fresh result.
